// File: rtl/systolic_mm_array.sv
// N x N output-stationary systolic array computing C = A*B, or C += A*B in accumulate mode.
// Each job streams column-of-A / row-of-B beats in, then the result is drained one row at a time.
module systolic_mm_array #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 40,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic            cfg_acc,
  input  logic [N*DW-1:0] a_col,
  input  logic [N*DW-1:0] b_row,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*AW-1:0] out_row,
  output logic [IW-1:0]   out_row_idx,
  output logic            busy
);

  // state  | meaning
  // IDLE   | waiting for the first beat of a job
  // LOAD   | accepting beats until in_last
  // FLUSH  | injecting zeros until the last product reaches PE(N-1,N-1)
  // DRAIN  | presenting result rows 0..N-1 to the consumer
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  localparam int FW = $clog2(2 * N);

  state_t          state, state_nxt;
  logic [FW-1:0]   flush_cnt;
  logic [IW-1:0]   row_cnt;
  logic [IW-1:0]   row_sel;
  logic [N*AW-1:0] row_pack;
  logic            take, clr;

  logic signed [DW-1:0]   inj_a [N];
  logic signed [DW-1:0]   inj_b [N];
  logic signed [DW-1:0]   a_sk  [N];
  logic signed [DW-1:0]   b_sk  [N];
  logic signed [DW-1:0]   a_in  [N][N];
  logic signed [DW-1:0]   b_in  [N][N];
  logic signed [2*DW-1:0] prod  [N][N];
  logic signed [DW-1:0]   a_pe  [N][N-1];
  logic signed [DW-1:0]   b_pe  [N-1][N];
  logic signed [AW-1:0]   acc   [N][N];

  assign in_ready    = (state == S_IDLE) || (state == S_LOAD);
  assign take        = in_valid && in_ready;
  assign clr         = take && (state == S_IDLE) && !cfg_acc;
  assign busy        = (state != S_IDLE);
  assign out_row_idx = row_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (take) state_nxt = in_last ? S_FLUSH : S_LOAD;
      S_LOAD:  if (take && in_last) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_cnt == '0) state_nxt = S_DRAIN;
      S_DRAIN: if (out_valid && out_ready && row_cnt == IW'(N - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Loaded with 2N-2 so FLUSH spans 2N-1 cycles, the skew depth of the far corner PE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (state != S_FLUSH && state_nxt == S_FLUSH) begin
      flush_cnt <= FW'(2 * N - 2);
    end else if (state == S_FLUSH && flush_cnt != '0) begin
      flush_cnt <= flush_cnt - FW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      inj_a[i] = take ? a_col[i*DW +: DW] : '0;
      inj_b[i] = take ? b_row[i*DW +: DW] : '0;
    end
  end

  // Lane i passes through i+1 registers so lane i enters the array i cycles after lane 0.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic signed [DW-1:0] sr_a [0:i];
    logic signed [DW-1:0] sr_b [0:i];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int d = 0; d <= i; d++) begin
          sr_a[d] <= '0;
          sr_b[d] <= '0;
        end
      end else begin
        sr_a[0] <= inj_a[i];
        sr_b[0] <= inj_b[i];
        for (int d = 1; d <= i; d++) begin
          sr_a[d] <= sr_a[d-1];
          sr_b[d] <= sr_b[d-1];
        end
      end
    end
    assign a_sk[i] = sr_a[i];
    assign b_sk[i] = sr_b[i];
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_sk[i];
      b_in[0][i] = b_sk[i];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_pe[i][j-1];
        b_in[j][i] = b_pe[j-1][i];
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i][j] = (2*DW)'(a_in[i][j]) * (2*DW)'(b_in[i][j]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) acc[i][j] <= '0;
        for (int j = 0; j < N - 1; j++) begin
          a_pe[i][j] <= '0;
          b_pe[j][i] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= clr ? '0 : acc[i][j] + AW'(prod[i][j]);
        end
        for (int j = 0; j < N - 1; j++) begin
          a_pe[i][j] <= a_in[i][j];
          b_pe[j][i] <= b_in[j][i];
        end
      end
    end
  end

  // The first DRAIN cycle latches row 0; later loads fetch the row after the one being accepted.
  assign row_sel = out_valid ? row_cnt + IW'(1) : row_cnt;

  always_comb begin
    row_pack = '0;
    for (int j = 0; j < N; j++) row_pack[j*AW +: AW] = acc[row_sel][j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      row_cnt   <= '0;
    end else if (state == S_DRAIN) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_row   <= row_pack;
      end else if (out_ready) begin
        if (row_cnt == IW'(N - 1)) begin
          out_valid <= 1'b0;
          row_cnt   <= '0;
        end else begin
          row_cnt <= row_cnt + IW'(1);
          out_row <= row_pack;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_mm_array.sv
// Bench for systolic_mm_array: directed and randomized jobs checked against a plain
// matrix-product model with wrap-around at the accumulator width.
module tb_systolic_mm_array;
  localparam int N = 4, DW = 16, AW = 40, IW = 2, KMAX = 8;

  logic            clk = 1'b0, rst = 1'b1;
  logic            in_valid = 1'b0, in_last = 1'b0, cfg_acc = 1'b0, out_ready = 1'b1;
  logic [N*DW-1:0] a_col = '0, b_row = '0;
  logic            in_ready, out_valid, busy;
  logic [N*AW-1:0] out_row;
  logic [IW-1:0]   out_row_idx;

  systolic_mm_array #(.N(N), .DW(DW), .AW(AW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .cfg_acc(cfg_acc), .a_col(a_col), .b_row(b_row), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_row_idx(out_row_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int ja [N][KMAX];
  int jb [KMAX][N];
  longint cm [N][N];
  logic [N*AW-1:0] rcv [N];
  logic [N*AW-1:0] tmp_row;
  int cyc_last;

  task automatic check(input string tag, input logic [N*AW-1:0] obs, input logic [N*AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*AW-1:0] exp_row(input int r);
    logic [N*AW-1:0] v;
    longint t;
    v = '0;
    for (int j = 0; j < N; j++) begin
      t = cm[r][j];
      v[j*AW +: AW] = t[AW-1:0];
    end
    return v;
  endfunction

  task automatic set_ident_b();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ja[i][k] = (i == k) ? 1 : 0;
        jb[k][i] = 4 * k + i + 1;
      end
  endtask

  task automatic set_const(input int av, input int bv);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        ja[i][k] = av;
        jb[k][i] = bv;
      end
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        ja[i][k] = int'($urandom_range(65535)) - 32768;
        jb[k][i] = int'($urandom_range(65535)) - 32768;
      end
  endtask

  task automatic run_job(input int k, input bit acc, input int gap);
    int v;
    if (!acc)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) cm[i][j] = 0;
    for (int b = 0; b < k; b++) begin
      for (int i = 0; i < N; i++) begin
        v = ja[i][b]; a_col[i*DW +: DW] = v[DW-1:0];
        v = jb[b][i]; b_row[i*DW +: DW] = v[DW-1:0];
      end
      in_valid = 1'b1;
      in_last  = (b == k - 1);
      cfg_acc  = acc;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          cm[i][j] += longint'(ja[i][b]) * longint'(jb[b][j]);
      @(negedge clk);
      if (gap > 0 && b < k - 1) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int g = 0; g < gap; g++) begin
          a_col = {$urandom(), $urandom()};
          b_row = {$urandom(), $urandom()};
          @(negedge clk);
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    a_col    = {$urandom(), $urandom()};
    b_row    = {$urandom(), $urandom()};
    cyc_last = cyc;
  endtask

  task automatic drain(input int stall_row, input int stall_n, input bit chk_lat);
    int w;
    for (int r = 0; r < N; r++) begin
      w = 0;
      while (out_valid !== 1'b1 && w < 100) begin
        @(negedge clk);
        w++;
      end
      check("out_valid_wait", out_valid, 1);
      if (out_valid !== 1'b1) return;
      if (r == 0 && chk_lat) check("latency", cyc - cyc_last, 2 * N);
      check("row_idx", out_row_idx, r);
      check("row_data", out_row, exp_row(r));
      rcv[r] = out_row;
      if (r == stall_row) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_idx", out_row_idx, r);
          check("stall_data", out_row, rcv[r]);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("busy_after_drain", busy, 0);
    check("valid_after_drain", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) cm[i][j] = 0;

    // reset values
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_row", out_row, 0);
    check("rst_idx", out_row_idx, 0);
    in_valid = 1'b1;
    @(negedge clk);
    check("rst_no_accept", busy, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // identity A, back-to-back
    set_ident_b();
    run_job(4, 1'b0, 0);
    check("busy_in_flush", busy, 1);
    check("in_ready_flush", in_ready, 0);
    drain(-1, 0, 1'b1);
    tmp_row = rcv[1];
    check("ident_c11", tmp_row[AW +: AW], 6);

    // extreme operands
    set_const(-32768, -32768);
    run_job(4, 1'b0, 0);
    drain(-1, 0, 1'b1);
    tmp_row = rcv[3];
    check("min_sq_c33", tmp_row[3*AW +: AW], 40'h01_0000_0000);
    set_const(32767, -32768);
    run_job(1, 1'b0, 0);
    drain(-1, 0, 1'b1);
    tmp_row = rcv[2];
    check("max_min_c20", tmp_row[AW-1:0], 40'hFF_C000_8000);

    // bubbles between beats
    set_ident_b();
    run_job(4, 1'b0, 3);
    drain(-1, 0, 1'b1);

    // backpressure on row 1
    run_job(4, 1'b0, 0);
    drain(1, 5, 1'b1);

    // accumulate mode
    run_job(4, 1'b0, 0);
    drain(-1, 0, 1'b0);
    run_job(4, 1'b1, 0);
    drain(-1, 0, 1'b0);
    tmp_row = rcv[0];
    check("acc_c00_double", tmp_row[AW-1:0], 2);
    run_job(4, 1'b0, 0);
    drain(-1, 0, 1'b0);

    // reset in the third FLUSH cycle
    run_job(4, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midflush_rst_valid", out_valid, 0);
    check("midflush_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) cm[i][j] = 0;
    @(negedge clk);
    run_job(4, 1'b0, 0);
    drain(-1, 0, 1'b1);

    // reset during DRAIN, then accumulate onto what must be zeroed accumulators
    set_random();
    run_job(3, 1'b0, 0);
    repeat (2 * N + 1) @(negedge clk);
    check("pre_rst_drain_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("middrain_rst_valid", out_valid, 0);
    check("middrain_rst_row", out_row, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) cm[i][j] = 0;
    @(negedge clk);
    set_random();
    run_job(5, 1'b1, 1);
    drain(-1, 0, 1'b1);

    // randomized jobs
    for (int t = 0; t < 8; t++) begin
      set_random();
      run_job(int'($urandom_range(1, KMAX)), 1'($urandom_range(1)), int'($urandom_range(2)));
      drain(int'($urandom_range(N)), int'($urandom_range(1, 3)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
